// File: rtl/psu_sync_pkg.sv
// -----------------------------------------------------------------------------
// psu_sync_pkg
// Shared definitions for the PSU synchronisation generator:
//   - FSM state encoding (IDLE / RUN / DRAIN)
//   - legacy frequency presets (half period H and phase step S)
//   - cfg_legal(): configuration legality check shared by RTL and bench
// -----------------------------------------------------------------------------
package psu_sync_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Legacy fixed-mode equivalents.
  localparam int SYNC_H_16M = 16;
  localparam int SYNC_S_16M = 4;
  localparam int SYNC_H_8M  = 8;
  localparam int SYNC_S_8M  = 2;

  // A configuration is usable when the half period is non-zero and the last
  // phase edge still lands inside the half period. The product is formed at
  // 64 bits so no field width can truncate it.
  function automatic logic cfg_legal(input logic [31:0] h,
                                     input logic [31:0] s,
                                     input int          nph);
    logic [63:0] span;
    span = 64'(nph - 1) * 64'(s);
    return (h != 32'd0) && (span < 64'(h));
  endfunction

endpackage

// File: rtl/psu_sync_edge_seq.sv
// -----------------------------------------------------------------------------
// psu_sync_edge_seq
// Edge sequencer and phase output registers. Counts the half period (hc),
// tracks which half is running (hb) and walks through the phases in order,
// toggling ph[idx] when hc reaches its threshold thr = idx*S.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   active_i  high while the controlling FSM is in RUN or DRAIN
//   h_i       shadowed half period H (clk cycles)
//   s_i       shadowed phase step S (clk cycles)
//   ph_o      registered phase outputs, ph_o[0] leads
//   strobe_o  registered one-cycle pulse at each period start
//   last_o    high on the last cycle of a period (hb=1, hc=H-1)
// -----------------------------------------------------------------------------
module psu_sync_edge_seq
  import psu_sync_pkg::*;
#(
  parameter int NPH  = 4,
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            active_i,
  input  logic [DIVW-1:0] h_i,
  input  logic [DIVW-1:0] s_i,
  output logic [NPH-1:0]  ph_o,
  output logic            strobe_o,
  output logic            last_o
);

  localparam int IW = $clog2(NPH + 1);          // idx must reach NPH
  localparam int TW = DIVW + $clog2(NPH) + 1;   // thr can reach NPH*S

  logic [DIVW-1:0] hc_q, hc_d;
  logic            hb_q, hb_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   thr_q, thr_d;
  logic [NPH-1:0]  ph_q, ph_d;
  logic            strobe_q, strobe_d;

  logic [IW-1:0]   cur_idx;
  logic [TW-1:0]   cur_thr;
  logic            hc_last;

  assign hc_last = (hc_q == h_i - DIVW'(1));
  assign last_o  = active_i & hb_q & hc_last;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    hc_d     = hc_q;
    hb_d     = hb_q;
    idx_d    = idx_q;
    thr_d    = thr_q;
    ph_d     = ph_q;
    strobe_d = 1'b0;
    // Each half period restarts the walk from phase 0 at threshold 0.
    cur_idx  = (hc_q == '0) ? '0 : idx_q;
    cur_thr  = (hc_q == '0) ? '0 : thr_q;

    if (!active_i) begin
      hc_d  = '0;
      hb_d  = 1'b0;
      idx_d = '0;
      thr_d = '0;
      ph_d  = '0;
    end else begin
      strobe_d = ~hb_q && (hc_q == '0);

      // With S>0 at most one phase matches per cycle; with S=0 every phase
      // shares threshold 0 and all toggle together.
      for (int j = 0; j < NPH; j++) begin
        if (cur_idx < IW'(NPH) && cur_thr == TW'(hc_q)) begin
          for (int k = 0; k < NPH; k++) begin
            if (cur_idx == IW'(k)) ph_d[k] = ~hb_q;
          end
          cur_idx = cur_idx + IW'(1);
          cur_thr = cur_thr + TW'(s_i);
        end
      end
      idx_d = cur_idx;
      thr_d = cur_thr;

      if (hc_last) begin
        hc_d = '0;
        hb_d = ~hb_q;
      end else begin
        hc_d = hc_q + DIVW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc_q     <= '0;
      hb_q     <= 1'b0;
      idx_q    <= '0;
      thr_q    <= '0;
      ph_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      hc_q     <= hc_d;
      hb_q     <= hb_d;
      idx_q    <= idx_d;
      thr_q    <= thr_d;
      ph_q     <= ph_d;
      strobe_q <= strobe_d;
    end
  end

  assign ph_o     = ph_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/psu_sync_gen_n.sv
// -----------------------------------------------------------------------------
// psu_sync_gen_n
// Parametrised PSU synchronisation generator: NPH square-wave phases with a
// programmable half period H and inter-phase step S. Configuration is
// shadowed and only reloaded on the last cycle of a period; dropping en lets
// the running period drain before going idle.
//
// Ports:
//   clk            system clock (8 or 16 MHz)
//   reset          asynchronous active-low reset
//   en             run request, level sensitive
//   half_period    H, clk cycles per output half period
//   phase_step     S, clk cycles between successive phase edges
//   ph             phase outputs, ph[0] leads
//   running        high in RUN and DRAIN
//   period_strobe  one-cycle pulse at each period start
//   cfg_err        sampled configuration is illegal
// -----------------------------------------------------------------------------
module psu_sync_gen_n
  import psu_sync_pkg::*;
#(
  parameter int NPH  = 4,
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [DIVW-1:0] half_period,
  input  logic [DIVW-1:0] phase_step,
  output logic [NPH-1:0]  ph,
  output logic            running,
  output logic            period_strobe,
  output logic            cfg_err
);

  logic [1:0]      state_q, state_d;
  logic [DIVW-1:0] h_q, h_d;
  logic [DIVW-1:0] s_q, s_d;
  logic            cfg_err_q, cfg_err_d;

  logic            in_legal;
  logic            period_last;
  logic            active;

  // Legality is judged on the values about to enter the shadow registers,
  // so the period that follows always runs on exactly what was checked.
  assign in_legal = cfg_legal(32'(half_period), 32'(phase_step), NPH);
  assign active   = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    s_d       = s_q;
    cfg_err_d = cfg_err_q;

    unique case (state_q)
      ST_IDLE: begin
        h_d = half_period;
        s_d = phase_step;
        if (en) begin
          if (in_legal) begin
            state_d   = ST_RUN;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          cfg_err_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (period_last) begin
          h_d = half_period;
          s_d = phase_step;
          if (!in_legal) begin
            state_d   = ST_IDLE;
            cfg_err_d = 1'b1;
          end else if (!en) begin
            state_d = ST_IDLE;
          end
        end else if (!en) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (period_last) begin
          h_d = half_period;
          s_d = phase_step;
          if (en && in_legal) begin
            state_d = ST_RUN;
          end else begin
            state_d   = ST_IDLE;
            cfg_err_d = en;
          end
        end else if (en) begin
          // Counters are untouched, so resuming mid-period is glitch-free.
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cfg_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      s_q       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      s_q       <= s_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  psu_sync_edge_seq #(
    .NPH  (NPH),
    .DIVW (DIVW)
  ) u_edge_seq (
    .clk      (clk),
    .reset    (reset),
    .active_i (active),
    .h_i      (h_q),
    .s_i      (s_q),
    .ph_o     (ph),
    .strobe_o (period_strobe),
    .last_o   (period_last)
  );

  assign running = active;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_psu_sync_gen_n.sv
// -----------------------------------------------------------------------------
// tb_psu_sync_gen_n
// Directed self-checking bench for psu_sync_gen_n (NPH=4, DIVW=8).
// Cycle n is the clock interval after the n-th sampled rising edge; en is
// raised during cycle 0, so the first ph[0] rise is expected in cycle 2.
// -----------------------------------------------------------------------------
module tb_psu_sync_gen_n;
  import psu_sync_pkg::*;

  localparam int NPH  = 4;
  localparam int DIVW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            en = 1'b0;
  logic [DIVW-1:0] half_period = '0;
  logic [DIVW-1:0] phase_step = '0;
  logic [NPH-1:0]  ph;
  logic            running;
  logic            period_strobe;
  logic            cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  psu_sync_gen_n #(
    .NPH  (NPH),
    .DIVW (DIVW)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .half_period   (half_period),
    .phase_step    (phase_step),
    .ph            (ph),
    .running       (running),
    .period_strobe (period_strobe),
    .cfg_err       (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset pulse, then load a configuration and raise en in cycle 0.
  task automatic start(input int h, input int s);
    reset = 1'b0;
    en    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    cyc         = 0;
    half_period = DIVW'(h);
    phase_step  = DIVW'(s);
    en          = 1'b1;
  endtask

  // Expected phase vector c cycles after the first ph[0] rise of a run.
  function automatic logic [NPH-1:0] exp_ph(input int c, input int h, input int s);
    logic [NPH-1:0] v;
    int p;
    v = '0;
    if (c >= 0) begin
      p = c % (2 * h);
      for (int k = 0; k < NPH; k++) v[k] = (p >= k * s) && (p < h + k * s);
    end
    return v;
  endfunction

  // Hand-computed ph snapshots for H=16, S=4.
  int          t1_cyc [9] = '{2, 6, 10, 14, 18, 22, 26, 30, 34};
  logic [3:0]  t1_ph  [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                              4'b1100, 4'b1000, 4'b0000, 4'b0001};

  // Configuration boundary table: H, S, legal.
  int          cfg_h  [5] = '{4, 6, 7, 0, 5};
  int          cfg_s  [5] = '{2, 2, 2, 0, 0};
  logic        cfg_ok [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // ---------------- reset state ----------------
    tick();
    check("rst_ph", 32'(ph), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_strobe", 32'(period_strobe), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);

    // ---------------- 1: 16 MHz mode, H=16 S=4 ----------------
    start(SYNC_H_16M, SYNC_S_16M);
    for (int i = 0; i < 70; i++) begin
      check("t1_ph", 32'(ph), 32'(exp_ph(cyc - 2, 16, 4)));
      check("t1_strobe", 32'(period_strobe),
            32'((cyc >= 2) && ((cyc - 2) % 32 == 0)));
      check("t1_running", 32'(running), 32'(cyc >= 1));
      for (int r = 0; r < 9; r++)
        if (cyc == t1_cyc[r]) check("t1_table", 32'(ph), 32'(t1_ph[r]));
      tick();
    end

    // ---------------- 2: 8 MHz mode, H=8 S=2 ----------------
    start(SYNC_H_8M, SYNC_S_8M);
    for (int i = 0; i < 48; i++) begin
      check("t2_ph", 32'(ph), 32'(exp_ph(cyc - 2, 8, 2)));
      check("t2_strobe", 32'(period_strobe),
            32'((cyc >= 2) && ((cyc - 2) % 16 == 0)));
      tick();
    end

    // ---------------- 3: en dropped mid first half, drain ----------------
    start(8, 2);
    for (int i = 0; i < 26; i++) begin
      if (cyc == 4) en = 1'b0;
      check("t3_ph", 32'(ph), 32'((cyc < 18) ? exp_ph(cyc - 2, 8, 2) : 4'b0000));
      check("t3_running", 32'(running), 32'((cyc >= 1) && (cyc <= 16)));
      check("t3_strobe", 32'(period_strobe), 32'(cyc == 2));
      tick();
    end

    // ---------------- 3b: en re-raised during drain ----------------
    start(8, 2);
    for (int i = 0; i < 40; i++) begin
      if (cyc == 4) en = 1'b0;
      if (cyc == 6) en = 1'b1;
      check("t3b_ph", 32'(ph), 32'(exp_ph(cyc - 2, 8, 2)));
      check("t3b_running", 32'(running), 32'(cyc >= 1));
      tick();
    end

    // ---------------- 4: configuration legality boundaries ----------------
    for (int r = 0; r < 5; r++) begin
      start(cfg_h[r], cfg_s[r]);
      tick();
      tick();
      check("t4_running", 32'(running), 32'(cfg_ok[r]));
      check("t4_cfg_err", 32'(cfg_err), 32'(!cfg_ok[r]));
      check("t4_ph", 32'(ph),
            32'(!cfg_ok[r] ? 4'b0000 : (cfg_s[r] == 0 ? 4'b1111 : 4'b0001)));
      tick();
      check("t4_cfg_err_hold", 32'(cfg_err), 32'(!cfg_ok[r]));
      en = 1'b0;
      tick();
      check("t4_cfg_err_clr", 32'(cfg_err), 32'd0);
    end

    // ---------------- 5: reconfigure 16/4 -> 8/2 mid-period ----------------
    start(16, 4);
    for (int i = 0; i < 56; i++) begin
      if (cyc == 10) begin
        half_period = DIVW'(8);
        phase_step  = DIVW'(2);
      end
      check("t5_ph", 32'(ph),
            32'((cyc < 34) ? exp_ph(cyc - 2, 16, 4) : exp_ph(cyc - 34, 8, 2)));
      check("t5_strobe", 32'(period_strobe),
            32'((cyc == 2) || (cyc == 34) || (cyc == 50)));
      tick();
    end

    // ---------------- 6: asynchronous reset mid-run ----------------
    start(16, 4);
    repeat (10) tick();
    check("t6_pre_ph", 32'(ph), 32'(4'b0111));
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_ph", 32'(ph), 32'd0);
    check("t6_async_running", 32'(running), 32'd0);
    tick();
    check("t6_held_ph", 32'(ph), 32'd0);
    reset = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 20; i++) begin
      check("t6_restart_ph", 32'(ph), 32'(exp_ph(cyc - 2, 16, 4)));
      check("t6_restart_strobe", 32'(period_strobe), 32'(cyc == 2));
      tick();
    end

    en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
